// File: rtl/dvs_uart_pkg.sv
// Shared constants, TX state encoding and event record for the DVS event UART link.
package dvs_uart_pkg;

    localparam logic [7:0] PING_BYTE   = 8'hFF;
    localparam logic [7:0] ECHO_BYTE   = 8'h55;
    localparam logic [3:0] GESTURE_HDR = 4'hA;
    localparam int         PKT_BYTES   = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SEND,
        TX_GUARD,
        TX_WAIT
    } tx_state_e;

    typedef struct packed {
        logic [6:0] x;
        logic [6:0] y;
        logic       pol;
        logic [7:0] ts;
    } dvs_event_t;

    localparam int EVENT_W = $bits(dvs_event_t);

    // Byte 0 keeps its MSB clear so it can never be mistaken for a ping.
    function automatic logic [7:0] pkt_byte(input dvs_event_t ev, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {1'b0, ev.x};
            2'd1:    b = {1'b0, ev.y};
            2'd2:    b = {7'b0, ev.pol};
            default: b = ev.ts;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dvs_event_fifo.sv
// Synchronous event FIFO: registered write, combinational head read, count-based flags.
module dvs_event_fifo
    import dvs_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [EVENT_W-1:0] wr_data,
    input  logic               pop,
    output logic [EVENT_W-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [EVENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/dvs_uart_event_sender.sv
// Serialises buffered DVS events as [X, Y, POL, TS] UART packets and decodes returned bytes.
// Optional ping/echo path enabled by defining DVS_TX_PING_EN.
module dvs_uart_event_sender
    import dvs_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [6:0]  ev_x,
    input  logic [6:0]  ev_y,
    input  logic        ev_pol,
    input  logic [7:0]  ev_ts,
    input  logic        ping_req,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [1:0]  gesture,
    output logic        gesture_valid,
    output logic        echo_ok,
    output logic [7:0]  bad_resp_cnt,
    output logic [15:0] pkts_sent
);

`ifdef DVS_TX_PING_EN
    localparam bit PING_EN = 1'b1;
`else
    localparam bit PING_EN = 1'b0;
`endif

    dvs_event_t ev_in;
    dvs_event_t fifo_head;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;

    tx_state_e  state_q, state_d;
    dvs_event_t pkt_q, pkt_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic       is_ping_q, is_ping_d;
    logic       ping_pend_q, ping_pend_d;
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [15:0] pkts_q, pkts_d;

    logic [1:0] gesture_q, gesture_d;
    logic       gesture_valid_q, gesture_valid_d;
    logic       echo_ok_q, echo_ok_d;
    logic [7:0] bad_q, bad_d;
    logic       is_gesture;
    logic       is_echo;

    assign ev_in = {ev_x, ev_y, ev_pol, ev_ts};

    dvs_event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (ev_valid),
        .wr_data(ev_in),
        .pop    (fifo_pop),
        .rd_data(fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign ev_ready = !fifo_full;

    // Pings are only picked up in IDLE, so they always fall between packets.
    always_comb begin
        state_d     = state_q;
        pkt_d       = pkt_q;
        byte_idx_d  = byte_idx_q;
        is_ping_d   = is_ping_q;
        ping_pend_d = ping_pend_q || (PING_EN && ping_req);
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;
        pkts_d      = pkts_q;
        fifo_pop    = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (ping_pend_q) begin
                    is_ping_d = 1'b1;
                    state_d   = TX_SEND;
                end else if (!fifo_empty) begin
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                fifo_pop   = 1'b1;
                pkt_d      = fifo_head;
                byte_idx_d = 2'd0;
                is_ping_d  = 1'b0;
                state_d    = TX_SEND;
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = is_ping_q ? PING_BYTE : pkt_byte(pkt_q, byte_idx_q);
                    if (is_ping_q) begin
                        ping_pend_d = 1'b0;
                    end
                    state_d = TX_GUARD;
                end
            end
            TX_GUARD: begin
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    if (is_ping_q) begin
                        state_d = TX_IDLE;
                    end else if (byte_idx_q != 2'(PKT_BYTES - 1)) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = TX_SEND;
                    end else begin
                        pkts_d  = pkts_q + 16'd1;
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    assign is_gesture = (rx_data[7:4] == GESTURE_HDR) && (rx_data[3:2] == 2'b00);
    assign is_echo    = PING_EN && (rx_data == ECHO_BYTE);

    always_comb begin
        gesture_d       = gesture_q;
        gesture_valid_d = 1'b0;
        echo_ok_d       = 1'b0;
        bad_d           = bad_q;
        if (rx_valid) begin
            if (is_gesture) begin
                gesture_d       = rx_data[1:0];
                gesture_valid_d = 1'b1;
            end else if (is_echo) begin
                echo_ok_d = 1'b1;
            end else if (bad_q != 8'hFF) begin
                bad_d = bad_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= TX_IDLE;
            pkt_q           <= '0;
            byte_idx_q      <= 2'd0;
            is_ping_q       <= 1'b0;
            ping_pend_q     <= 1'b0;
            tx_valid_q      <= 1'b0;
            tx_data_q       <= 8'd0;
            pkts_q          <= 16'd0;
            gesture_q       <= 2'd0;
            gesture_valid_q <= 1'b0;
            echo_ok_q       <= 1'b0;
            bad_q           <= 8'd0;
        end else begin
            state_q         <= state_d;
            pkt_q           <= pkt_d;
            byte_idx_q      <= byte_idx_d;
            is_ping_q       <= is_ping_d;
            ping_pend_q     <= ping_pend_d;
            tx_valid_q      <= tx_valid_d;
            tx_data_q       <= tx_data_d;
            pkts_q          <= pkts_d;
            gesture_q       <= gesture_d;
            gesture_valid_q <= gesture_valid_d;
            echo_ok_q       <= echo_ok_d;
            bad_q           <= bad_d;
        end
    end

    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign pkts_sent     = pkts_q;
    assign gesture       = gesture_q;
    assign gesture_valid = gesture_valid_q;
    assign echo_ok       = echo_ok_q;
    assign bad_resp_cnt  = bad_q;

endmodule

// File: tb/tb_dvs_uart_event_sender.sv
// Self-checking bench for dvs_uart_event_sender: byte-queue model of the event link plus RX decode model.
module tb_dvs_uart_event_sender;

    localparam int DEPTH = 8;

`ifdef DVS_TX_PING_EN
    localparam bit PING_ON = 1'b1;
`else
    localparam bit PING_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ev_valid;
    logic        ev_ready;
    logic [6:0]  ev_x;
    logic [6:0]  ev_y;
    logic        ev_pol;
    logic [7:0]  ev_ts;
    logic        ping_req;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [1:0]  gesture;
    logic        gesture_valid;
    logic        echo_ok;
    logic [7:0]  bad_resp_cnt;
    logic [15:0] pkts_sent;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         pkts_exp;
    int         bad_exp;
    logic [1:0] gest_exp;
    bit         hold_busy;
    int         busy_cnt;

    dvs_uart_event_sender #(
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_x         (ev_x),
        .ev_y         (ev_y),
        .ev_pol       (ev_pol),
        .ev_ts        (ev_ts),
        .ping_req     (ping_req),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .gesture      (gesture),
        .gesture_valid(gesture_valid),
        .echo_ok      (echo_ok),
        .bad_resp_cnt (bad_resp_cnt),
        .pkts_sent    (pkts_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy for a few cycles after each send pulse, or held by the test.
    initial begin
        busy_cnt = 0;
        tx_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) busy_cnt = 0;
            else if (tx_valid) busy_cnt = $urandom_range(2, 6);
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = hold_busy || (busy_cnt > 0);
        end
    end

    // Wire capture of every transmitted byte.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_valid) obs_q.push_back(tx_data);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Offers one event and waits (bounded) for it to be accepted; the model records its 4 bytes.
    task automatic applyStimulus(input logic [6:0] x, input logic [6:0] y, input logic pol,
                                 input logic [7:0] ts);
        bit ok;
        bit acc;
        ok       = 1'b0;
        ev_x     = x;
        ev_y     = y;
        ev_pol   = pol;
        ev_ts    = ts;
        ev_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            acc = ev_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        ev_valid = 1'b0;
        if (ok) begin
            exp_q.push_back({1'b0, x});
            exp_q.push_back({1'b0, y});
            exp_q.push_back({7'b0, pol});
            exp_q.push_back(ts);
            pkts_exp++;
        end else begin
            checkOutput("accept_timeout", 32'(ok), 32'd1);
        end
    endtask

    task automatic drainAndCompare(input string tag);
        logic [7:0] o;
        for (int i = 0; i < 3000 && obs_q.size() < exp_q.size(); i++) tick();
        repeat (30) tick();
        checkOutput({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
            checkOutput($sformatf("%s_byte%0d", tag, i), o, exp_q[i]);
        end
        checkOutput({tag, "_pkts"}, pkts_sent, pkts_exp);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic rxByte(input logic [7:0] b, input string tag);
        bit gv;
        bit eo;
        gv       = 1'b0;
        eo       = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        if (b inside {[8'hA0:8'hA3]}) begin
            gv       = 1'b1;
            gest_exp = b[1:0];
        end else if (PING_ON && b == 8'h55) begin
            eo = 1'b1;
        end else if (bad_exp < 255) begin
            bad_exp++;
        end
        checkOutput({tag, "_gvalid"}, gesture_valid, gv);
        checkOutput({tag, "_gesture"}, gesture, gest_exp);
        checkOutput({tag, "_echo"}, echo_ok, eo);
        checkOutput({tag, "_bad"}, bad_resp_cnt, bad_exp);
        tick();
        checkOutput({tag, "_pulse_end"}, {gesture_valid, echo_ok}, 2'b00);
    endtask

    initial begin
        int k;
        int cnt;
        logic [7:0] b;

        rst       = 1'b1;
        ev_valid  = 1'b0;
        ev_x      = '0;
        ev_y      = '0;
        ev_pol    = 1'b0;
        ev_ts     = '0;
        ping_req  = 1'b0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        hold_busy = 1'b0;
        pkts_exp  = 0;
        bad_exp   = 0;
        gest_exp  = 2'd0;
        $display("[TB] start, ping path %0s", PING_ON ? "enabled" : "disabled");

        repeat (3) tick();
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_gesture", gesture, 0);
        checkOutput("rst_gesture_valid", gesture_valid, 0);
        checkOutput("rst_echo_ok", echo_ok, 0);
        checkOutput("rst_bad_cnt", bad_resp_cnt, 0);
        checkOutput("rst_pkts", pkts_sent, 0);
        checkOutput("rst_ev_ready", ev_ready, 1);
        rst = 1'b0;
        repeat (3) tick();

        // Single event and first-byte latency.
        applyStimulus(7'd5, 7'd9, 1'b1, 8'h3C);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (tx_valid) begin
                k = i;
                break;
            end
        end
        checkOutput("latency", k, 3);
        drainAndCompare("single");

        // Randomised event stream with random gaps and transmitter timing.
        for (int n = 0; n < 16; n++) begin
            applyStimulus(7'($urandom), 7'($urandom), 1'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        drainAndCompare("random");

        // Backpressure: one event sits in the packet register, DEPTH fill the FIFO.
        hold_busy = 1'b1;
        repeat (2) tick();
        for (int n = 0; n < DEPTH + 1; n++) begin
            applyStimulus(7'($urandom), 7'($urandom), 1'($urandom), 8'($urandom));
        end
        tick();
        checkOutput("bp_ready_low", ev_ready, 0);
        repeat (40) tick();
        checkOutput("bp_ready_still_low", ev_ready, 0);
        checkOutput("bp_no_tx_while_busy", obs_q.size(), 0);
        hold_busy = 1'b0;
        drainAndCompare("backpressure");

        // Ping raised mid-packet goes out after the final byte (or never, without the ping path).
        applyStimulus(7'h11, 7'h22, 1'b0, 8'hC3);
        for (int i = 0; i < 300 && obs_q.size() < 2; i++) tick();
        ping_req = 1'b1;
        tick();
        ping_req = 1'b0;
        if (PING_ON) exp_q.push_back(8'hFF);
        drainAndCompare("ping_mid");

        // Repeated ping requests while one is pending collapse into a single 0xFF.
        hold_busy = 1'b1;
        tick();
        for (int n = 0; n < 3; n++) begin
            ping_req = 1'b1;
            tick();
            ping_req = 1'b0;
            repeat (3) tick();
        end
        repeat (10) tick();
        hold_busy = 1'b0;
        if (PING_ON) exp_q.push_back(8'hFF);
        drainAndCompare("ping_dedup");

        rxByte(8'h55, "echo");

        // Response decoding: directed then random bytes.
        rxByte(8'hA2, "dec_a2");
        rxByte(8'h13, "dec_13");
        rxByte(8'hA0, "dec_a0");
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            case ($urandom_range(0, 5))
                0, 1:    b = {6'b101000, b[1:0]};
                2:       b = 8'h55;
                default: ;
            endcase
            rxByte(b, $sformatf("rx_rand%0d", n));
        end

        // Saturation of the bad-response counter.
        for (int n = 0; n < 300; n++) begin
            b = 8'($urandom);
            if (b inside {[8'hA0:8'hA3]} || b == 8'h55) b = 8'h13;
            rxByte(b, "sat");
        end
        checkOutput("sat_final", bad_resp_cnt, 255);

        // Reset in the middle of a 3-packet burst.
        for (int n = 0; n < 3; n++) begin
            applyStimulus(7'($urandom), 7'($urandom), 1'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 300 && obs_q.size() < 3; i++) tick();
        rst = 1'b1;
        tick();
        tick();
        checkOutput("midrst_ev_ready", ev_ready, 1);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        pkts_exp = 0;
        bad_exp  = 0;
        gest_exp = 2'd0;
        checkOutput("midrst_pkts", pkts_sent, 0);
        checkOutput("midrst_bad", bad_resp_cnt, 0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_valid) cnt++;
        end
        checkOutput("midrst_no_tx", cnt, 0);
        checkOutput("midrst_ready_after", ev_ready, 1);
        applyStimulus(7'h7F, 7'h00, 1'b1, 8'hFF);
        drainAndCompare("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
